instr_fetch_unit: RTL and testbench

Fetch stage of the AY8 core. Sits between `Memory` (over the shared 8-bit multiplexed address/data bus) and the decode/execute stage. Autonomously reads sequential instruction bytes starting at the program counter and buffers them, tagged with their address, in a small queue. Decode/execute pops bytes through a valid/ready handshake and redirects the PC on jumps.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// AY8 fetch stage: sequential byte fetch over the multiplexed memory bus into a
// small {data, pc} queue drained by decode through a valid/ready handshake.
module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [7:0]  RESET_PC = 8'h00
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       fetch_en,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       bus_ale,
   output logic       bus_rd,
   input  logic [7:0] bus_in,
   input  logic       bus_dv,
   output logic       ins_valid,
   output logic [7:0] ins_data,
   output logic [7:0] ins_pc,
   input  logic       ins_ready,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   output logic       busy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DRAIN} state_t;

   state_t           r_state, w_state_d;
   logic [7:0]       r_pc, w_pc_d;
   logic [CNT_W-1:0] r_count, w_count_d;
   logic             r_pending, w_pending_d;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [7:0]       r_mem_data [DEPTH];
   logic [7:0]       r_mem_pc   [DEPTH];
   logic [CNT_W:0]   w_occ;
   logic             w_push, w_pop, w_room;
   logic [7:0]       r_bus_out;
   logic             r_bus_oe, r_bus_ale, r_bus_rd, r_busy;

   always_comb begin
      w_pop       = (r_count != '0) && ins_ready && !redirect;
      w_push      = (r_state == WAIT) && bus_dv && !redirect;
      w_count_d   = redirect ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      w_pc_d      = redirect ? redirect_pc : (w_push ? r_pc + 8'h01 : r_pc);

      w_pending_d = r_pending;
      if (r_state == ADDR) begin
         w_pending_d = 1'b1;
      end else if ((r_state == WAIT || r_state == DRAIN) && bus_dv) begin
         w_pending_d = 1'b0;
      end

      // Occupancy after this cycle's push/pop, counting the reserved in-flight slot
      w_occ  = {1'b0, w_count_d} + {{CNT_W{1'b0}}, w_pending_d};
      w_room = w_occ < (CNT_W+1)'(DEPTH);

      w_state_d = r_state;
      case (r_state)
         IDLE: begin
            if (fetch_en && !redirect && w_room) w_state_d = ADDR;
         end
         ADDR: begin
            w_state_d = redirect ? DRAIN : WAIT;
         end
         WAIT: begin
            if (redirect) begin
               w_state_d = bus_dv ? IDLE : DRAIN;
            end else if (bus_dv) begin
               w_state_d = (fetch_en && w_room) ? ADDR : IDLE;
            end
         end
         DRAIN: begin
            if (bus_dv) w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= IDLE;
         r_pc      <= RESET_PC;
         r_count   <= '0;
         r_pending <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_bus_out <= 8'h00;
         r_bus_oe  <= 1'b0;
         r_bus_ale <= 1'b0;
         r_bus_rd  <= 1'b0;
         r_busy    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem_data[PTR_W'(i)] <= 8'h00;
            r_mem_pc[PTR_W'(i)]   <= 8'h00;
         end
      end else begin
         r_state   <= w_state_d;
         r_pc      <= w_pc_d;
         r_count   <= w_count_d;
         r_pending <= w_pending_d;
         // Bus strobes are registered from the next state so they align with it
         r_bus_out <= (w_state_d == ADDR) ? w_pc_d : 8'h00;
         r_bus_oe  <= (w_state_d == ADDR);
         r_bus_ale <= (w_state_d == ADDR);
         r_bus_rd  <= (w_state_d != IDLE);
         r_busy    <= (w_state_d != IDLE);
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus_in;
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (redirect) begin
            r_rd_ptr <= r_wr_ptr;
         end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign bus_out   = r_bus_out;
   assign bus_oe    = r_bus_oe;
   assign bus_ale   = r_bus_ale;
   assign bus_rd    = r_bus_rd;
   assign busy      = r_busy;
   assign ins_valid = (r_count != '0);
   assign ins_data  = r_mem_data[r_rd_ptr];
   assign ins_pc    = r_mem_pc[r_rd_ptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model.
module tb_instr_fetch_unit;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       fetch_en = 1'b0;
   logic [7:0] bus_out;
   logic       bus_oe, bus_ale, bus_rd;
   logic [7:0] bus_in = 8'h00;
   logic       bus_dv = 1'b0;
   logic       ins_valid;
   logic [7:0] ins_data, ins_pc;
   logic       ins_ready = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic       busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [256];
   int         lat = 0;
   logic       m_out = 1'b0;
   logic [7:0] m_addr = 8'h00;
   int         m_cnt = 0;

   instr_fetch_unit #(.DEPTH(4), .RESET_PC(8'h00)) dut (
      .CLK(CLK), .RST(RST), .fetch_en(fetch_en),
      .bus_out(bus_out), .bus_oe(bus_oe), .bus_ale(bus_ale), .bus_rd(bus_rd),
      .bus_in(bus_in), .bus_dv(bus_dv),
      .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Memory: latches the address on bus_ale, answers with one bus_dv pulse lat cycles into WAIT
   always @(negedge CLK) begin
      if (RST) begin
         m_out  = 1'b0;
         bus_dv = 1'b0;
      end else if (bus_ale) begin
         m_out  = 1'b1;
         m_addr = bus_out;
         m_cnt  = lat;
         bus_dv = 1'b0;
      end else if (m_out && bus_rd && m_cnt == 0) begin
         bus_dv = 1'b1;
         bus_in = mem[m_addr];
         m_out  = 1'b0;
      end else begin
         bus_dv = 1'b0;
         if (m_out && m_cnt != 0) m_cnt = m_cnt - 1;
      end
   end

   task automatic do_reset();
      RST = 1'b1; fetch_en = 1'b0; ins_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 8'h00; lat = 0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; fetch_en = 1'b1;
      @(negedge CLK);
      checks++; if (bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus_out got=%h exp=00", bus_out); end
      checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL reset_bus_oe got=%b exp=0", bus_oe); end
      checks++; if (bus_ale !== 1'b0) begin failures++; $display("FAIL reset_bus_ale got=%b exp=0", bus_ale); end
      checks++; if (bus_rd !== 1'b0) begin failures++; $display("FAIL reset_bus_rd got=%b exp=0", bus_rd); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_ins_valid got=%b exp=0", ins_valid); end
      checks++; if (ins_data !== 8'h00) begin failures++; $display("FAIL reset_ins_data got=%h exp=00", ins_data); end
      checks++; if (ins_pc !== 8'h00) begin failures++; $display("FAIL reset_ins_pc got=%h exp=00", ins_pc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      do_reset();
      repeat (3) @(negedge CLK);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_fetch_busy got=%b exp=0", busy); end
   endtask

   task automatic test_sequential();
      logic [7:0] ale_a[$];
      logic [7:0] got_d[$];
      logic [7:0] got_p[$];
      int first_v = -1;
      do_reset();
      fetch_en = 1'b1; ins_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge CLK);
         if (bus_ale && c <= 8) ale_a.push_back(bus_out);
         if (ins_valid) begin
            if (first_v < 0) first_v = c;
            got_d.push_back(ins_data);
            got_p.push_back(ins_pc);
         end
      end
      checks++; if (first_v != 3) begin failures++; $display("FAIL seq_latency got=%0d exp=3", first_v); end
      checks++; if (ale_a.size() != 4) begin failures++; $display("FAIL seq_ale_count got=%0d exp=4", ale_a.size()); end
      checks++; if (got_d.size() != 4) begin failures++; $display("FAIL seq_byte_count got=%0d exp=4", got_d.size()); end
      for (int k = 0; k < 4; k++) begin
         if (k < ale_a.size()) begin
            checks++; if (ale_a[k] !== 8'(k)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", k, ale_a[k], 8'(k)); end
         end
         if (k < got_d.size()) begin
            checks++; if (got_d[k] !== 8'(8'h10 + k)) begin failures++; $display("FAIL seq_data%0d got=%h exp=%h", k, got_d[k], 8'(8'h10 + k)); end
            checks++; if (got_p[k] !== 8'(k)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", k, got_p[k], 8'(k)); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ale_a[$];
      do_reset();
      fetch_en = 1'b1; ins_ready = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge CLK);
         if (bus_ale) ale_a.push_back(bus_out);
      end
      checks++; if (ale_a.size() != 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", ale_a.size()); end
      if (ale_a.size() >= 4) begin
         checks++; if (ale_a[3] !== 8'h03) begin failures++; $display("FAIL bp_last_addr got=%h exp=03", ale_a[3]); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy got=%b exp=0", busy); end
      checks++; if (bus_rd !== 1'b0) begin failures++; $display("FAIL bp_bus_rd got=%b exp=0", bus_rd); end
      checks++; if (ins_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", ins_valid); end
      checks++; if (ins_data !== 8'h10) begin failures++; $display("FAIL bp_head_data got=%h exp=10", ins_data); end
      checks++; if (ins_pc !== 8'h00) begin failures++; $display("FAIL bp_head_pc got=%h exp=00", ins_pc); end
      ale_a.delete();
      ins_ready = 1'b1;
      @(negedge CLK);
      ins_ready = 1'b0;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge CLK);
         if (bus_ale) ale_a.push_back(bus_out);
      end
      checks++; if (ale_a.size() != 1) begin failures++; $display("FAIL bp_resume_count got=%0d exp=1", ale_a.size()); end
      if (ale_a.size() >= 1) begin
         checks++; if (ale_a[0] !== 8'h04) begin failures++; $display("FAIL bp_resume_addr got=%h exp=04", ale_a[0]); end
      end
      checks++; if (ins_data !== 8'h11) begin failures++; $display("FAIL bp_new_head got=%h exp=11", ins_data); end
      checks++; if (ins_pc !== 8'h01) begin failures++; $display("FAIL bp_new_head_pc got=%h exp=01", ins_pc); end
   endtask

   task automatic test_redirect_wait();
      logic       seen_ale = 1'b0;
      logic       early = 1'b0;
      logic       got = 1'b0;
      logic [7:0] a0 = 8'h00;
      logic [7:0] gd = 8'h00;
      logic [7:0] gp = 8'h00;
      int         ale_c = -1;
      do_reset();
      fetch_en = 1'b1; ins_ready = 1'b0;
      @(negedge CLK);          // c1 ADDR
      @(negedge CLK);          // c2 WAIT, first byte answered
      lat = 3;
      @(negedge CLK);          // c3 second ADDR
      checks++; if (ins_valid !== 1'b1 || ins_data !== 8'h10) begin failures++; $display("FAIL rw_prefill got=%b/%h exp=1/10", ins_valid, ins_data); end
      @(negedge CLK);          // c4 WAIT, response still 3 cycles out
      redirect = 1'b1; redirect_pc = 8'h02;
      @(negedge CLK);          // c5 DRAIN
      redirect = 1'b0; lat = 0;
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL rw_flush got=%b exp=0", ins_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rw_drain_busy got=%b exp=1", busy); end
      checks++; if (bus_rd !== 1'b1) begin failures++; $display("FAIL rw_drain_rd got=%b exp=1", bus_rd); end
      checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL rw_drain_oe got=%b exp=0", bus_oe); end
      for (int c = 6; c <= 30; c++) begin
         @(negedge CLK);
         if (ins_valid && !seen_ale) early = 1'b1;
         if (bus_ale && !seen_ale) begin seen_ale = 1'b1; a0 = bus_out; ale_c = c; end
         if (ins_valid && !got) begin got = 1'b1; gd = ins_data; gp = ins_pc; end
      end
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL rw_late_byte_kept got=%b exp=0", early); end
      checks++; if (a0 !== 8'h02) begin failures++; $display("FAIL rw_next_addr got=%h exp=02", a0); end
      checks++; if (ale_c != 9) begin failures++; $display("FAIL rw_addr_cycle got=%0d exp=9", ale_c); end
      checks++; if (got !== 1'b1 || gd !== 8'h12 || gp !== 8'h02) begin failures++; $display("FAIL rw_byte got=%b/%h/%h exp=1/12/02", got, gd, gp); end
   endtask

   task automatic test_redirect_dv();
      logic       got = 1'b0;
      logic [7:0] gd = 8'h00;
      logic [7:0] gp = 8'h00;
      do_reset();
      fetch_en = 1'b1; ins_ready = 1'b0;
      @(negedge CLK);          // c1 ADDR
      @(negedge CLK);          // c2 WAIT with bus_dv
      redirect = 1'b1; redirect_pc = 8'h05;
      @(negedge CLK);          // c3 IDLE
      redirect = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_no_drain got=%b exp=0", busy); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL rd_dropped got=%b exp=0", ins_valid); end
      @(negedge CLK);          // c4 ADDR
      checks++; if (bus_ale !== 1'b1 || bus_out !== 8'h05) begin failures++; $display("FAIL rd_next_req got=%b/%h exp=1/05", bus_ale, bus_out); end
      for (int c = 5; c <= 12; c++) begin
         @(negedge CLK);
         if (ins_valid && !got) begin got = 1'b1; gd = ins_data; gp = ins_pc; end
      end
      checks++; if (got !== 1'b1 || gd !== 8'h15 || gp !== 8'h05) begin failures++; $display("FAIL rd_byte got=%b/%h/%h exp=1/15/05", got, gd, gp); end
   endtask

   task automatic test_pc_wrap();
      logic [7:0] ale_a[$];
      logic [7:0] got_d[$];
      logic [7:0] got_p[$];
      logic [7:0] exp_a [4];
      exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
      do_reset();
      redirect = 1'b1; redirect_pc = 8'hFE; fetch_en = 1'b1; ins_ready = 1'b1;
      @(negedge CLK);
      redirect = 1'b0;
      checks++; if (busy !== 1'b0 || bus_ale !== 1'b0) begin failures++; $display("FAIL wrap_idle_redirect got=%b/%b exp=0/0", busy, bus_ale); end
      for (int c = 2; c <= 20; c++) begin
         @(negedge CLK);
         if (bus_ale) ale_a.push_back(bus_out);
         if (ins_valid) begin got_d.push_back(ins_data); got_p.push_back(ins_pc); end
      end
      fetch_en = 1'b0; ins_ready = 1'b0;
      checks++; if (ale_a.size() < 4 || got_d.size() < 4) begin failures++; $display("FAIL wrap_counts got=%0d/%0d exp=4/4", ale_a.size(), got_d.size()); end
      for (int k = 0; k < 4; k++) begin
         if (k < ale_a.size()) begin
            checks++; if (ale_a[k] !== exp_a[k]) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, ale_a[k], exp_a[k]); end
         end
         if (k < got_d.size()) begin
            checks++; if (got_p[k] !== exp_a[k]) begin failures++; $display("FAIL wrap_pc%0d got=%h exp=%h", k, got_p[k], exp_a[k]); end
            checks++; if (got_d[k] !== 8'(exp_a[k] + 8'h10)) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", k, got_d[k], 8'(exp_a[k] + 8'h10)); end
         end
      end
   endtask

   task automatic test_async_reset();
      logic       seen = 1'b0;
      logic       got = 1'b0;
      logic [7:0] a0 = 8'hFF;
      logic [7:0] gd = 8'h00;
      logic [7:0] gp = 8'hFF;
      do_reset();
      fetch_en = 1'b1; ins_ready = 1'b0;
      repeat (4) @(negedge CLK);   // c4: second WAIT with one byte queued
      checks++; if (busy !== 1'b1 || ins_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b/%b exp=1/1", busy, ins_valid); end
      RST = 1'b1;
      #1;
      checks++; if (bus_rd !== 1'b0) begin failures++; $display("FAIL ar_bus_rd got=%b exp=0", bus_rd); end
      checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL ar_bus_oe got=%b exp=0", bus_oe); end
      checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", ins_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
      @(negedge CLK);
      RST = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLK);
         if (bus_ale && !seen) begin seen = 1'b1; a0 = bus_out; end
         if (ins_valid && !got) begin got = 1'b1; gd = ins_data; gp = ins_pc; end
      end
      checks++; if (a0 !== 8'h00) begin failures++; $display("FAIL ar_restart_addr got=%h exp=00", a0); end
      checks++; if (got !== 1'b1 || gd !== 8'h10 || gp !== 8'h00) begin failures++; $display("FAIL ar_restart_byte got=%b/%h/%h exp=1/10/00", got, gd, gp); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_dv();
      test_pc_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
